// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the dual-port data memory.
package data_mem_pkg;

   typedef enum logic {CLEAR, RUN} mem_state_t;

   function automatic int mem_depth(input int addr_size);
      return 1 << addr_size;
   endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks clr_addr over every word, then raises ready_o.
module mem_clear_seq
   import data_mem_pkg::*;
#(
   parameter int ADDR_SIZE = 5
) (
   input  logic                 clk,
   input  logic                 rstn,
   output logic                 clr_we_o,
   output logic [ADDR_SIZE-1:0] clr_addr_o,
   output logic                 ready_o
);

   mem_state_t           state_q, state_d;
   logic [ADDR_SIZE:0]   clr_addr_q, clr_addr_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // NOTE: defaults first, so every path assigns every output and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      unique case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + {{ADDR_SIZE{1'b0}}, 1'b1};
            // MSB set means the last word has just been cleared; no second pass.
            if (clr_addr_d[ADDR_SIZE]) state_d = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end

   assign clr_we_o   = rstn && (state_q == CLEAR);
   assign clr_addr_o = clr_addr_q[ADDR_SIZE-1:0];
   assign ready_o    = (state_q == RUN);

endmodule

// File: rtl/data_mem_dp.sv
// Dual-port data memory with registered read and post-reset clear.
// DATA_MEM_BYPASS_EN selects write-first on same-address collisions (default read-first).
module data_mem_dp
   import data_mem_pkg::*;
#(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 5
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 WE,
   input  logic [ADDR_SIZE-1:0] WR_ADDR,
   input  logic [DATA_SIZE-1:0] WR_DATA,
   input  logic                 RE,
   input  logic [ADDR_SIZE-1:0] RD_ADDR,
   output logic [DATA_SIZE-1:0] RD_DATA,
   output logic                 RD_VALID,
   output logic                 READY
);

   localparam int DEPTH = mem_depth(ADDR_SIZE);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic                 clr_we;
   logic [ADDR_SIZE-1:0] clr_addr;
   logic                 ready;
   logic                 wr_en, rd_en;
   logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;

   mem_clear_seq #(.ADDR_SIZE(ADDR_SIZE)) u_clear_seq (
      .clk        (clk),
      .rstn       (rstn),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr),
      .ready_o    (ready)
   );

   assign wr_en = rstn && ready && WE;
   assign rd_en = rstn && ready && RE;

   // NOTE: the array has no reset branch; the clear sequencer zeroes it, keeping it mappable to RAM.
   always_ff @(posedge clk) begin
      if (clr_we)     mem_q[clr_addr] <= '0;
      else if (wr_en) mem_q[WR_ADDR]  <= WR_DATA;
   end

   always_comb begin
      rd_valid_d = rd_en;
      rd_data_d  = rd_data_q;
      if (rd_en) begin
`ifdef DATA_MEM_BYPASS_EN
         if (wr_en && (WR_ADDR == RD_ADDR)) rd_data_d = WR_DATA;
         else                               rd_data_d = mem_q[RD_ADDR];
`else
         rd_data_d = mem_q[RD_ADDR];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign RD_DATA  = rd_data_q;
   assign RD_VALID = rd_valid_q;
   assign READY    = ready;

endmodule
